event_frame_sender: RTL
=======================

Name: event_frame_sender

Overview:
Generalised UART event-frame transmitter. It serialises one event code, then PAYLOAD_BYTES payload bytes, then an optional XOR checksum, one byte per UART transaction. It sits between the game/event logic and the shared UART TX, and replaces the per-event single-byte senders such as end-game or score. It adds multi-byte payloads, a payload snapshot, a checksum, acknowledge-timeout re-issue and a re-arm interlock.

Parameters:
EVENT_CODE, 8'hAE, header byte sent first in every frame.
PAYLOAD_BYTES, 1, number of payload bytes (1..16).
CHECKSUM_EN, 0, when 1 append XOR of header and all payload bytes as the final byte.
ACK_TIMEOUT, 15, cycles to wait for uart_ocupado to rise after an iniciar_envio pulse before re-issuing it (1..255).

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
habilitar_envio  in  1  level request to send one frame
uart_ocupado  in  1  UART TX busy, high while a byte is being shifted out
buffer_envio  in  8*PAYLOAD_BYTES  payload; most significant byte is sent first
iniciar_envio  out  1  one-cycle strobe to start a UART byte transmission
dado_saida  out  8  byte presented to the UART; valid and stable whenever not IDLE
envio_concluido  out  1  one-cycle pulse when the last byte of the frame has finished
ocupado  out  1  high from frame acceptance until envio_concluido, inclusive

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, iniciar_envio=0, dado_saida=8'h00, envio_concluido=0, ocupado=0, byte index=0, checksum=0, timeout counter=0, armed=1. Reset mid-frame aborts immediately; no concluido pulse.
- Frame length L = 1 + PAYLOAD_BYTES + CHECKSUM_EN. Byte k order: k=0 is EVENT_CODE; k=1..PAYLOAD_BYTES is the snapshot, MSB byte first; k=L-1 is the checksum when CHECKSUM_EN=1.
- IDLE: if habilitar_envio && armed, then:
  - snapshot buffer_envio into an internal register;
  - set checksum=EVENT_CODE, index=0, ocupado=1, armed=0;
  - go to ISSUE.
  - Payload changes after acceptance do not affect the frame.
- armed returns to 1 only on a cycle when habilitar_envio==0 in IDLE. A held-high request therefore sends exactly one frame.
- ISSUE: dado_saida=byte[index]. If uart_ocupado==0, assert iniciar_envio for exactly one cycle, clear the timeout counter and go to WAIT_ACK. Otherwise stay, with no strobe.
- WAIT_ACK:
  - if uart_ocupado==1, go to WAIT_DONE;
  - else increment the counter; when counter==ACK_TIMEOUT, go back to ISSUE, which re-strobes the same byte.
- WAIT_DONE: wait for uart_ocupado==0.
  - Fold the byte into the checksum: checksum ^= byte[index]. Payload bytes only; the checksum byte itself is not folded.
  - If index==L-1, go to DONE; else index+1 and go to ISSUE.
- DONE: envio_concluido=1 for one cycle, ocupado=1 this cycle, then IDLE with ocupado=0.
- Minimum spacing between strobes: the strobe cycle, at least one WAIT_ACK cycle, the UART busy time, and one ISSUE cycle.
- dado_saida holds its last value in IDLE; it is never X after reset.
- iniciar_envio is never asserted while uart_ocupado==1 in the same cycle.
- Checksum byte = EVENT_CODE ^ payload bytes, computed on the snapshot (8-bit XOR, no carry).

Test Plan:
1. PAYLOAD_BYTES=1, CHECKSUM_EN=0, buffer=8'hC5, UART model busy 10 cycles after each strobe → exactly 2 strobes, with bytes AE then C5; one envio_concluido after the second busy falls; ocupado low afterwards.
2. PAYLOAD_BYTES=2, CHECKSUM_EN=1, buffer=16'h853C → bytes AE, 85, 3C, 17 in that order; 4 strobes; one concluido pulse.
3. Hold habilitar_envio high for 200 cycles → exactly one frame. Drop it for 1 cycle and raise it again → a second frame starts.
4. UART model ignores the first strobe (busy never rises), ACK_TIMEOUT=15 → strobe re-issued 15 cycles after the first with the same dado_saida=AE; the frame then completes normally.
5. Change buffer_envio from 16'h853C to 16'hFFFF one cycle after acceptance → transmitted payload is still 85, 3C; checksum is 17.
6. Assert reset=0 while the second byte is busy → all outputs return to reset values the next cycle, with no concluido. After release, a new request sends a complete frame from AE.

Source files
------------

// File: rtl/event_frame_sender_if.sv
// rtl/event_frame_sender_if.sv - handshake bundle between event logic, frame sender and UART TX
//
// Purpose: groups the request, payload, UART handshake and status signals of
// event_frame_sender so they can be passed as one port.
// Signals:
//   habilitar_envio  level request to send one frame
//   uart_ocupado     UART TX busy while a byte is shifted out
//   buffer_envio     payload, most significant byte sent first
//   iniciar_envio    one-cycle strobe starting one UART byte
//   dado_saida       byte presented to the UART
//   envio_concluido  one-cycle pulse when the frame has finished
//   ocupado          high from frame acceptance until envio_concluido
// Modports: master = frame sender, slave = surrounding logic / UART.
interface event_frame_sender_if #(
  parameter int PAYLOAD_BYTES = 1
);
  logic                       habilitar_envio;
  logic                       uart_ocupado;
  logic [8*PAYLOAD_BYTES-1:0] buffer_envio;
  logic                       iniciar_envio;
  logic [7:0]                 dado_saida;
  logic                       envio_concluido;
  logic                       ocupado;

  modport master (
    input  habilitar_envio,
    input  uart_ocupado,
    input  buffer_envio,
    output iniciar_envio,
    output dado_saida,
    output envio_concluido,
    output ocupado
  );

  modport slave (
    output habilitar_envio,
    output uart_ocupado,
    output buffer_envio,
    input  iniciar_envio,
    input  dado_saida,
    input  envio_concluido,
    input  ocupado
  );
endinterface

// File: rtl/event_frame_sender.sv
// rtl/event_frame_sender.sv - UART event-frame transmitter (header, payload, optional XOR checksum)
//
// Purpose: sends EVENT_CODE, then PAYLOAD_BYTES bytes of a payload snapshot
// (MSB byte first), then optionally the XOR of header and payload, one byte
// per UART transaction. A strobe that the UART does not acknowledge within
// ACK_TIMEOUT cycles is re-issued. A held request sends one frame only.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous active-low reset
//   bus    event_frame_sender_if.master (request, payload, UART handshake, status)
module event_frame_sender #(
  parameter logic [7:0] EVENT_CODE    = 8'hAE,
  parameter int         PAYLOAD_BYTES = 1,
  parameter int         CHECKSUM_EN   = 0,
  parameter int         ACK_TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  event_frame_sender_if.master bus
);

  localparam int         PW        = 8 * PAYLOAD_BYTES;
  localparam int         FRAME_LEN = 1 + PAYLOAD_BYTES + CHECKSUM_EN;
  localparam logic [4:0] IDX_LAST  = 5'(FRAME_LEN - 1);
  localparam logic [4:0] IDX_PB    = 5'(PAYLOAD_BYTES);
  localparam logic [7:0] CNT_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_snap;
  logic [4:0]    r_idx;
  logic [7:0]    r_csum;
  logic [7:0]    r_cnt;
  logic          r_armed;
  logic [7:0]    r_dado;

  logic          w_accept;
  logic          w_strobe;
  logic          w_byte_done;
  logic [4:0]    w_next_idx;
  logic [7:0]    w_csum_next;

  assign w_next_idx  = r_idx + 5'd1;
  assign w_csum_next = r_csum ^ r_dado;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_strobe     = 1'b0;
    w_byte_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.habilitar_envio && r_armed) begin
          w_accept     = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Strobe is gated by the live busy flag so it can never overlap busy.
        if (!bus.uart_ocupado) begin
          w_strobe     = 1'b1;
          w_next_state = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (bus.uart_ocupado) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          // This cycle's increment would reach ACK_TIMEOUT: re-issue.
          w_next_state = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.uart_ocupado) begin
          w_byte_done  = 1'b1;
          w_next_state = (r_idx == IDX_LAST) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_idx   <= 5'd0;
      r_csum  <= 8'h00;
      r_cnt   <= 8'h00;
      r_armed <= 1'b1;
      r_dado  <= 8'h00;
    end else begin
      r_state <= w_next_state;

      if (r_state == S_IDLE && !bus.habilitar_envio) begin
        r_armed <= 1'b1;
      end

      if (w_accept) begin
        r_snap  <= bus.buffer_envio;
        r_csum  <= EVENT_CODE;
        r_idx   <= 5'd0;
        r_armed <= 1'b0;
        r_dado  <= EVENT_CODE;
      end

      if (w_strobe) begin
        r_cnt <= 8'h00;
      end else if (r_state == S_WAIT_ACK && !bus.uart_ocupado) begin
        r_cnt <= r_cnt + 8'h01;
      end

      // Only payload bytes are folded; the header is the checksum seed.
      if (w_byte_done && r_idx != 5'd0 && r_idx <= IDX_PB) begin
        r_csum <= w_csum_next;
      end

      // The snapshot is consumed as a shift register: its top byte is
      // always the next payload byte, so dado_saida is loaded one step
      // ahead and stays stable through ISSUE/WAIT_ACK/WAIT_DONE.
      if (w_byte_done && r_idx != IDX_LAST) begin
        r_idx <= w_next_idx;
        if (w_next_idx <= IDX_PB) begin
          r_dado <= r_snap[PW-1 -: 8];
          r_snap <= r_snap << 8;
        end else begin
          r_dado <= w_csum_next;
        end
      end
    end
  end

  assign bus.iniciar_envio   = w_strobe;
  assign bus.dado_saida      = r_dado;
  assign bus.envio_concluido = (r_state == S_DONE);
  assign bus.ocupado         = (r_state != S_IDLE);

endmodule
